// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands on accept; stage 2 holds the result and flags for the sink.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } alu_out_t;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_op_r;
  logic             adv1_s;
  logic             adv2_s;
  alu_out_t         alu_s;

  function automatic alu_out_t alu_eval(input logic [2:0]       f_op,
                                        input logic [WIDTH-1:0] f_a,
                                        input logic [WIDTH-1:0] f_b);
    alu_out_t         o;
    logic [WIDTH:0]   wide;
    o    = {($bits(alu_out_t)){1'b0}};
    wide = {(WIDTH+1){1'b0}};
    case (f_op)
      3'b000: begin
        wide  = {1'b0, f_a} + {1'b0, f_b};
        o.res = wide[WIDTH-1:0];
        o.c   = wide[WIDTH];
        o.v   = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (o.res[WIDTH-1] != f_a[WIDTH-1]);
      end
      3'b001: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        wide  = {1'b0, f_a} - {1'b0, f_b};
        o.res = wide[WIDTH-1:0];
        o.c   = wide[WIDTH];
        o.v   = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (o.res[WIDTH-1] != f_a[WIDTH-1]);
      end
      3'b010:  o.res = f_a & f_b;
      3'b011:  o.res = f_a | f_b;
      3'b100:  o.res = f_a ^ f_b;
      3'b101:  o.res = f_a << f_b[SHW-1:0];
      3'b110:  o.res = f_a >> f_b[SHW-1:0];
      3'b111:  o.res = {{(WIDTH-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
      default: o.res = {WIDTH{1'b0}};
    endcase
    o.z = (o.res == {WIDTH{1'b0}});
    o.n = o.res[WIDTH-1];
    return o;
  endfunction

  assign adv2_s   = ~out_valid | out_ready;
  assign adv1_s   = ~s1_valid_r | adv2_s;
  assign in_ready = adv1_s & ~reset;

  // Combinational ALU evaluation of the stage-1 operands.
  always_comb begin
    alu_s = alu_eval(s1_op_r, s1_a_r, s1_b_r);
  end

  // Stage 1: capture operands only on a real accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 3'b000;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= a;
        s1_b_r  <= b;
        s1_op_r <= op;
      end
    end
  end

  // Stage 2: result and flags, held stable while the sink stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (adv2_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        result <= alu_s.res;
        flag_c <= alu_s.c;
        flag_z <= alu_s.z;
        flag_n <= alu_s.n;
        flag_v <= alu_s.v;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model with an expectation queue,
// directed vectors pinned to hand-computed values, and a randomised handshake soak.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;

  typedef struct {
    logic [11:0] exp;
    int          cyc;
  } item_t;

  item_t       exp_q[$];
  logic [11:0] got_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cnt  = 0;
  bit          lat_check = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  // Reference: plain integer arithmetic, packed as {result, c, z, n, v}.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, r, sh;
    logic c, v;
    logic [7:0] res;
    ua = int'(x);
    ub = int'(y);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    sh = ub % 8;
    case (o)
      3'd0: begin r = ua + ub; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua * (1 << sh);
      3'd6: r = ua / (1 << sh);
      3'd7: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    res = 8'(r & 255);
    return {res, c, (res == 8'd0), res[7], v};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: checks outputs against the queue head every valid cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got result %0h with no pending op (cycle %0d)", result, cyc);
        end else begin
          check("out_vs_model", {result, flag_c, flag_z, flag_n, flag_v}, exp_q[0].exp);
          if (out_ready) begin
            if (lat_check) check("latency", cyc - exp_q[0].cyc, 2);
            got_log.push_back({result, flag_c, flag_z, flag_n, flag_v});
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{model(op, a, b), cyc});
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 for op %0d", o);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = 8'($urandom);
    b  = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] corner[4];
    corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  logic [11:0] lit_a[6];
  logic [11:0] lit_b[4];
  int          acc_start;

  initial begin
    lit_a = '{12'h108, 12'h7F1, 12'h004, 12'h010, 12'h080, 12'h010};
    lit_b = '{12'h050, 12'hA52, 12'h004, 12'h803};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = 3'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {result, flag_c, flag_z, flag_n, flag_v}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Pin the model itself against hand-computed values
    check("model_add", model(3'd0, 8'hF0, 8'h20), 12'h108);
    check("model_sub_ovf", model(3'd1, 8'h80, 8'h01), 12'h7F1);
    check("model_sub_zero", model(3'd1, 8'h03, 8'h03), 12'h004);
    check("model_slt", model(3'd7, 8'hFF, 8'h01), 12'h010);
    check("model_add_ovf", model(3'd0, 8'h7F, 8'h01), 12'h803);

    // Directed ops with out_ready held high: exact two-cycle latency
    lat_check = 1'b1;
    got_log.delete();
    send(3'd0, 8'hF0, 8'h20);
    send(3'd1, 8'h80, 8'h01);
    send(3'd1, 8'h03, 8'h03);
    send(3'd7, 8'hFF, 8'h01);
    send(3'd5, 8'h81, 8'h03);
    send(3'd6, 8'h81, 8'h07);
    drain();
    lat_check = 1'b0;
    check("dir_count", got_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_log.size()) check($sformatf("dir_lit%0d", i), got_log[i], lit_a[i]);
    end

    // Backpressure: two accepts fill the pipe, further inputs are ignored
    got_log.delete();
    out_ready = 1'b0;
    send(3'd2, 8'hA5, 8'h0F);
    send(3'd3, 8'hA0, 8'h05);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    a = 8'h00;
    @(negedge clk);
    check("full_hold_valid", out_valid, 1);
    @(posedge clk); #1;
    a = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    send(3'd0, 8'h7F, 8'h01);
    drain();
    check("bp_count", got_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_log.size()) check($sformatf("bp_lit%0d", i), got_log[i], lit_b[i]);
    end

    // Reset with two ops in flight
    send(3'd0, 8'h11, 8'h22);
    send(3'd1, 8'h33, 8'h44);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {result, flag_c, flag_z, flag_n, flag_v}, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    lat_check = 1'b1;
    got_log.delete();
    send(3'd0, 8'h01, 8'h02);
    drain();
    lat_check = 1'b0;
    check("postrst_count", got_log.size(), 1);
    if (got_log.size() > 0) check("postrst_lit", got_log[0], 12'h030);

    // Random soak with random in_valid / out_ready
    acc_start = acc_cnt;
    for (int k = 0; k < 20000 && (acc_cnt - acc_start) < 1000; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      op        = 3'($urandom_range(0, 7));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    drain();
    check("rand_accepts", ((acc_cnt - acc_start) >= 1000) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
